// File: rtl/switch_allocator.sv
// Per-router switch allocator: one round-robin arbiter per output port,
// registered crossbar selects, output-valid flags and input pop pulses.
module switch_allocator #(
    parameter int unsigned PORT_NUM  = 5,
    parameter int unsigned SEL_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [0:PORT_NUM-1]  reqValid,
    input  logic [SEL_WIDTH-1:0] reqPort [PORT_NUM],
    input  logic [0:PORT_NUM-1]  outReady,
    output logic [SEL_WIDTH-1:0] sel [PORT_NUM],
    output logic [0:PORT_NUM-1]  outValid,
    output logic [0:PORT_NUM-1]  grant
);

    localparam logic [SEL_WIDTH-1:0] IDLE = SEL_WIDTH'(PORT_NUM);

    logic [SEL_WIDTH-1:0] ptr       [PORT_NUM];
    logic [SEL_WIDTH-1:0] win       [PORT_NUM];
    logic                 found     [PORT_NUM];
    logic [0:PORT_NUM-1]  next_grant;
    int unsigned          idx;

    // An input granted last cycle is masked: its buffer pops only now.
    // Ports >= PORT_NUM never match any output index, so they are ignored.
    always_comb begin
        next_grant = '0;
        idx        = 0;
        for (int unsigned o = 0; o < PORT_NUM; o++) begin
            found[o] = 1'b0;
            win[o]   = '0;
            for (int unsigned k = 0; k < PORT_NUM; k++) begin
                idx = int'(ptr[o]) + k;
                if (idx >= PORT_NUM)
                    idx = idx - PORT_NUM;
                if (!found[o] && outReady[o] && reqValid[idx] && !grant[idx] &&
                    reqPort[idx] == SEL_WIDTH'(o)) begin
                    found[o] = 1'b1;
                    win[o]   = SEL_WIDTH'(idx);
                end
            end
            if (found[o])
                next_grant[win[o]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned o = 0; o < PORT_NUM; o++) begin
                sel[o] <= IDLE;
                ptr[o] <= '0;
            end
            outValid <= '0;
            grant    <= '0;
        end else begin
            for (int unsigned o = 0; o < PORT_NUM; o++) begin
                if (found[o]) begin
                    sel[o]      <= win[o];
                    outValid[o] <= 1'b1;
                    ptr[o]      <= (win[o] == SEL_WIDTH'(PORT_NUM - 1)) ? '0 : win[o] + 1'b1;
                end else begin
                    sel[o]      <= IDLE;
                    outValid[o] <= 1'b0;
                end
            end
            grant <= next_grant;
        end
    end

endmodule
